nco_gen: RTL and testbench

NCO_GEN -- requirements
Module: nco_gen

---
 rtl/nco_gen_if.sv | 32 +++
 rtl/nco_gen.sv | 128 ++++++++++++
 tb/tb_nco_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nco_gen_if.sv
// nco_gen control/sample bundle.
// master drives phase controls, slave is the NCO.
interface nco_gen_if #(
  parameter int PHASE_W = 8,
  parameter int DELTA_W = 4,
  parameter int OUT_W   = 20
);
  logic               enable;
  logic               preload;
  logic [PHASE_W-1:0] pl_data;
  logic               up_dn;
  logic [DELTA_W-1:0] delta;
  logic [1:0]         mode;
  logic [PHASE_W-1:0] qout;
  logic               wrap;
  logic [OUT_W-1:0]   wave_out;
  logic               wave_valid;

  modport master (
    output enable, preload, pl_data,
    output up_dn, delta, mode,
    input  qout, wrap,
    input  wave_out, wave_valid
  );

  modport slave (
    input  enable, preload, pl_data,
    input  up_dn, delta, mode,
    output qout, wrap,
    output wave_out, wave_valid
  );
endinterface

// File: rtl/nco_gen.sv
// Phase accumulator NCO with 2-stage waveform pipeline.
// NCO_QUARTER_WAVE_EN: quarter-wave sine table.
module nco_gen #(
  parameter int PHASE_W = 8,
  parameter int DELTA_W = 4,
  parameter int OUT_W   = 20
) (
  input logic   clk,
  input logic   reset,
  nco_gen_if.slave bus
);

`ifdef NCO_QUARTER_WAVE_EN
  localparam int TBL_AW = PHASE_W - 2;
`else
  localparam int TBL_AW = PHASE_W;
`endif
  localparam int TBL_D = 1 << TBL_AW;
  localparam int PAD   = OUT_W - PHASE_W;

  // Filled from outside; never reset.
  logic [OUT_W-1:0]   sin_table [TBL_D];

  logic [PHASE_W-1:0] acc_q;
  logic               wrap_q;
  logic [PHASE_W-1:0] step;
  logic [PHASE_W:0]   sum_up;
  logic [PHASE_W:0]   sum_dn;

  logic [PHASE_W-1:0] s1_ph;
  logic [1:0]         s1_mode;
  logic               s1_vld;

  logic [OUT_W-1:0]   wave_q;
  logic               vld_q;
  logic [OUT_W-1:0]   wave_nxt;

  logic [OUT_W-1:0]   sine_w;
  logic [OUT_W-1:0]   saw_w;
  logic [PHASE_W-1:0] tri_t;
  logic [OUT_W-1:0]   tri_w;
  logic [OUT_W-1:0]   sq_w;

  assign step   = PHASE_W'(bus.delta);
  assign sum_up = {1'b0, acc_q} + {1'b0, step};
  assign sum_dn = {1'b0, acc_q} - {1'b0, step};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.preload) begin
      acc_q  <= bus.pl_data;
      wrap_q <= 1'b0;
    end else if (bus.enable) begin
      if (bus.up_dn) begin
        acc_q  <= sum_up[PHASE_W-1:0];
        wrap_q <= sum_up[PHASE_W];
      end else begin
        acc_q  <= sum_dn[PHASE_W-1:0];
        wrap_q <= sum_dn[PHASE_W];
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_ph   <= '0;
      s1_mode <= 2'b00;
      s1_vld  <= 1'b0;
    end else begin
      s1_ph   <= acc_q;
      s1_mode <= bus.mode;
      s1_vld  <= 1'b1;
    end
  end

`ifdef NCO_QUARTER_WAVE_EN
  logic [1:0]        quad;
  logic [TBL_AW-1:0] qa;
  logic [TBL_AW-1:0] qidx;
  logic [OUT_W-1:0]  qtv;

  assign quad   = s1_ph[PHASE_W-1 -: 2];
  assign qa     = s1_ph[TBL_AW-1:0];
  assign qidx   = quad[0] ? ~qa : qa;
  assign qtv    = sin_table[qidx];
  assign sine_w = quad[1] ? ({OUT_W{1'b1}} - qtv)
                          : qtv;
`else
  assign sine_w = sin_table[s1_ph];
`endif

  assign saw_w = OUT_W'(s1_ph) << PAD;
  assign tri_t = {s1_ph[PHASE_W-2:0], 1'b0}
               ^ {PHASE_W{s1_ph[PHASE_W-1]}};
  assign tri_w = OUT_W'(tri_t) << PAD;
  assign sq_w  = {OUT_W{~s1_ph[PHASE_W-1]}};

  always_comb begin
    wave_nxt = '0;
    unique case (1'b1)
      (s1_mode == 2'b00): wave_nxt = sine_w;
      (s1_mode == 2'b01): wave_nxt = saw_w;
      (s1_mode == 2'b10): wave_nxt = tri_w;
      (s1_mode == 2'b11): wave_nxt = sq_w;
      default:            wave_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wave_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wave_q <= wave_nxt;
      vld_q  <= s1_vld;
    end
  end

  assign bus.qout       = acc_q;
  assign bus.wrap       = wrap_q;
  assign bus.wave_out   = wave_q;
  assign bus.wave_valid = vld_q;

endmodule

// File: tb/tb_nco_gen.sv
// Directed bench for nco_gen.
// Sine table written directly, checked by a local model.
module tb_nco_gen;
  localparam int PW = 8;
  localparam int DW = 4;
  localparam int OW = 20;
`ifdef NCO_QUARTER_WAVE_EN
  localparam int TAW = PW - 2;
`else
  localparam int TAW = PW;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nco_gen_if #(
    .PHASE_W(PW), .DELTA_W(DW), .OUT_W(OW)
  ) bus ();

  nco_gen #(
    .PHASE_W(PW), .DELTA_W(DW), .OUT_W(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q0, q1, q2;
  logic       ew;

  function automatic logic [19:0] tv(int i);
    return 20'((i * 4099) ^ (i << 11) ^ 32'h35A5);
  endfunction

  function automatic logic [19:0] sine_m(
    logic [7:0] q
  );
`ifdef NCO_QUARTER_WAVE_EN
    logic [5:0]  a;
    logic [5:0]  idx;
    logic [19:0] t;
    a   = q[5:0];
    idx = q[6] ? ~a : a;
    t   = tv(int'(idx));
    return q[7] ? (20'hFFFFF - t) : t;
`else
    return tv(int'(q));
`endif
  endfunction

  function automatic logic [8:0] nxt(
    logic [7:0] q, logic up, logic [3:0] d
  );
    if (up) return {1'b0, q} + 9'(d);
    return {1'b0, q} - 9'(d);
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_run(input int n);
    bus.preload = 1'b0;
    bus.enable  = 1'b1;
    bus.up_dn   = 1'b1;
    bus.delta   = 4'd1;
    bus.mode    = 2'b01;
    @(negedge clk);
    reset = 1'b1;
    q0 = 8'h00; q1 = 8'h00; q2 = 8'h00;
    for (int k = 1; k <= n; k++) begin
      tick();
      q2 = q1; q1 = q0;
      {ew, q0} = nxt(q0, 1'b1, 4'd1);
      chk("cnt_qout", bus.qout, q0);
      chk("cnt_wrap", bus.wrap, ew);
      chk("cnt_valid", bus.wave_valid, k >= 2);
      if (k >= 2)
        chk("cnt_saw", bus.wave_out, {q2, 12'h000});
    end
  endtask

  task automatic wave_vec(
    input string tag,
    input logic [7:0] ph,
    input logic [1:0] m,
    input logic [19:0] exp
  );
    bus.enable  = 1'b0;
    bus.preload = 1'b1;
    bus.pl_data = ph;
    bus.mode    = m;
    tick();
    bus.preload = 1'b0;
    tick();
    tick();
    chk({tag, "_q"}, bus.qout, ph);
    chk(tag, bus.wave_out, exp);
  endtask

  initial begin
    bus.enable  = 1'b0;
    bus.preload = 1'b0;
    bus.pl_data = '0;
    bus.up_dn   = 1'b1;
    bus.delta   = '0;
    bus.mode    = 2'b00;
    for (int i = 0; i < (1 << TAW); i++)
      dut.sin_table[i] = tv(i);
    #1 reset = 1'b0;
    #11;
    chk("rst_qout", bus.qout, 0);
    chk("rst_wrap", bus.wrap, 0);
    chk("rst_wave", bus.wave_out, 0);
    chk("rst_valid", bus.wave_valid, 0);

    count_run(257);

    bus.enable  = 1'b1;
    bus.preload = 1'b1;
    bus.pl_data = 8'h03;
    tick();
    chk("pl3_q", bus.qout, 8'h03);
    chk("pl3_wrap", bus.wrap, 0);
    bus.preload = 1'b0;
    bus.up_dn   = 1'b0;
    bus.delta   = 4'd5;
    tick();
    chk("dn_q", bus.qout, 8'hFE);
    chk("dn_wrap", bus.wrap, 1);
    bus.enable = 1'b0;
    tick();
    chk("hold_q", bus.qout, 8'hFE);
    chk("hold_wrap", bus.wrap, 0);
    bus.enable  = 1'b1;
    bus.up_dn   = 1'b1;
    bus.delta   = 4'd0;
    tick();
    chk("d0_q", bus.qout, 8'hFE);
    chk("d0_wrap", bus.wrap, 0);
    bus.delta   = 4'd3;
    bus.preload = 1'b1;
    bus.pl_data = 8'h80;
    tick();
    chk("pl80_q", bus.qout, 8'h80);
    chk("pl80_wrap", bus.wrap, 0);

    wave_vec("saw40", 8'h40, 2'b01, 20'h40000);
    wave_vec("sawFF", 8'hFF, 2'b01, 20'hFF000);
    wave_vec("sq7F", 8'h7F, 2'b11, 20'hFFFFF);
    wave_vec("sq80", 8'h80, 2'b11, 20'h00000);
    wave_vec("tri40", 8'h40, 2'b10, 20'h80000);
    wave_vec("triC0", 8'hC0, 2'b10, 20'h7F000);
    wave_vec("tri00", 8'h00, 2'b10, 20'h00000);
    wave_vec("sin47", 8'h47, 2'b00, sine_m(8'h47));
    wave_vec("sinC5", 8'hC5, 2'b00, sine_m(8'hC5));

    bus.mode    = 2'b00;
    bus.preload = 1'b1;
    bus.pl_data = 8'h10;
    tick();
    bus.preload = 1'b0;
    tick();
    tick();
    q0 = 8'h10; q1 = 8'h10; q2 = 8'h10;
    bus.enable = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      bus.delta = 4'(d);
      bus.up_dn = d[0];
      for (int c = 0; c < 1000; c++) begin
        tick();
        q2 = q1; q1 = q0;
        {ew, q0} = nxt(q0, bus.up_dn, bus.delta);
        chk("sw_qout", bus.qout, q0);
        chk("sw_wrap", bus.wrap, ew);
        chk("sw_sine", bus.wave_out, sine_m(q2));
      end
    end

    bus.pl_data = 8'h5A;
    bus.preload = 1'b1;
    tick();
    bus.preload = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_qout", bus.qout, 0);
    chk("ar_wrap", bus.wrap, 0);
    chk("ar_wave", bus.wave_out, 0);
    chk("ar_valid", bus.wave_valid, 0);
    tick();
    chk("ar_hold_q", bus.qout, 0);
    chk("ar_hold_v", bus.wave_valid, 0);
    count_run(6);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
